// File: rtl/comparator_pkg.sv
// Shared types for the comparator: one-hot result encoding and width limit.
`default_nettype none

package comparator_pkg;

  localparam int CMP_MAX_WIDTH = 64;

  // CMP_NONE exists only as the reset value; a registered result is always one-hot.
  typedef enum logic [2:0] {
    CMP_NONE = 3'b000,
    CMP_LT   = 3'b001,
    CMP_EQ   = 3'b010,
    CMP_GT   = 3'b100
  } cmp_result_t;

  function automatic cmp_result_t cmp_encode(input logic gt, input logic eq);
    cmp_result_t res;
    if (eq) begin
      res = CMP_EQ;
    end else if (gt) begin
      res = CMP_GT;
    end else begin
      res = CMP_LT;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_cmp_cell.sv
// Merges two adjacent (gt, eq) segment results; the more significant segment decides unless equal.
`default_nettype none

module cmp_cell
  import comparator_pkg::*;
(
  input  logic gt_hi_i,
  input  logic eq_hi_i,
  input  logic gt_lo_i,
  input  logic eq_lo_i,
  output logic gt_o,
  output logic eq_o
);

  assign gt_o = gt_hi_i | (eq_hi_i & gt_lo_i);
  assign eq_o = eq_hi_i & eq_lo_i;

endmodule

`default_nettype wire

// File: rtl/comparator.sv
// Registered WIDTH-bit magnitude comparator with one-hot greater/equal/less flags.
`default_nettype none

module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             greater,
  output logic             equal,
  output logic             less
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LEAVES = 1 << LEVELS;

  logic [LEAVES-1:0] w_leaf_gt;
  logic [LEAVES-1:0] w_leaf_eq;

  // Pad leaves are "equal", which is the identity for the merge so they never affect the result.
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i >= WIDTH) begin : g_pad
      assign w_leaf_gt[i] = 1'b0;
      assign w_leaf_eq[i] = 1'b1;
    end else if (SIGNED && (i == WIDTH - 1)) begin : g_sign
      // A set sign bit means negative, so the operand roles swap at the MSB.
      assign w_leaf_gt[i] = b[i] & ~a[i];
      assign w_leaf_eq[i] = ~(a[i] ^ b[i]);
    end else begin : g_bit
      assign w_leaf_gt[i] = a[i] & ~b[i];
      assign w_leaf_eq[i] = ~(a[i] ^ b[i]);
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = LEAVES >> l;
    logic [N-1:0] gt;
    logic [N-1:0] eq;
    if (l == 0) begin : g_leaves
      assign gt = w_leaf_gt;
      assign eq = w_leaf_eq;
    end else begin : g_merge
      for (genvar j = 0; j < N; j++) begin : g_cell
        cmp_cell u_cell (
          .gt_hi_i (g_lvl[l-1].gt[2*j+1]),
          .eq_hi_i (g_lvl[l-1].eq[2*j+1]),
          .gt_lo_i (g_lvl[l-1].gt[2*j]),
          .eq_lo_i (g_lvl[l-1].eq[2*j]),
          .gt_o    (gt[j]),
          .eq_o    (eq[j])
        );
      end
    end
  end

  logic w_root_gt;
  logic w_root_eq;
  assign w_root_gt = g_lvl[LEVELS].gt[0];
  assign w_root_eq = g_lvl[LEVELS].eq[0];

  cmp_result_t result_d, result_q;
  logic        valid_d, valid_q;

  always_comb begin
    result_d = result_q;
    valid_d  = in_valid;
    if (in_valid) begin
      result_d = cmp_encode(w_root_gt, w_root_eq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= CMP_NONE;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid               = valid_q;
  assign {greater, equal, less}  = result_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator.sv
// Randomised and directed bench for comparator across several WIDTH/SIGNED configurations.
`default_nettype none

module tb_comparator;

  localparam int NDUT = 8;
  localparam int WS [NDUT] = '{4, 4, 1, 1, 8, 8, 64, 64};
  localparam bit SS [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] stim_a   = '0;
  logic [63:0] stim_b   = '0;

  logic ov [NDUT];
  logic gt [NDUT];
  logic eq [NDUT];
  logic lt [NDUT];

  logic       exp_v;
  logic [2:0] exp_f [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    comparator #(.WIDTH(WS[g]), .SIGNED(SS[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (stim_a[WS[g]-1:0]),
      .b         (stim_b[WS[g]-1:0]),
      .out_valid (ov[g]),
      .greater   (gt[g]),
      .equal     (eq[g]),
      .less      (lt[g])
    );
  end

  // Reference ordering from plain integer arithmetic; returns {gt, eq, lt}.
  function automatic logic [2:0] model(input int w, input bit s, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ua, ub;
    longint      sa, sb;
    ua = (w == 64) ? a : (a & ((64'd1 << w) - 64'd1));
    ub = (w == 64) ? b : (b & ((64'd1 << w) - 64'd1));
    sa = longint'(ua << (64 - w)) >>> (64 - w);
    sb = longint'(ub << (64 - w)) >>> (64 - w);
    if (s) begin
      if (sa > sb) return 3'b100;
      if (sa == sb) return 3'b010;
      return 3'b001;
    end
    if (ua > ub) return 3'b100;
    if (ua == ub) return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_v <= 1'b0;
      for (int i = 0; i < NDUT; i++) exp_f[i] <= 3'b000;
    end else begin
      exp_v <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < NDUT; i++) exp_f[i] <= model(WS[i], SS[i], stim_a, stim_b);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({ov[i], gt[i], eq[i], lt[i]} !== {exp_v, exp_f[i]}) begin
        errors++;
        $display("FAIL model dut%0d W%0d S%0d: got v/gt/eq/lt=%b%b%b%b expected %b%b at %0t",
                 i, WS[i], SS[i], ov[i], gt[i], eq[i], lt[i], exp_v, exp_f[i], $time);
      end
      if (ov[i] === 1'b1) begin
        checks++;
        if ($countones({gt[i], eq[i], lt[i]}) != 1) begin
          errors++;
          $display("FAIL onehot dut%0d: got flags %b%b%b required exactly one set",
                   i, gt[i], eq[i], lt[i]);
        end
      end
    end
  end

  task automatic check_lit(input string name, input int idx, input logic [3:0] req);
    logic [3:0] act;
    act = {ov[idx], gt[idx], eq[idx], lt[idx]};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got v/gt/eq/lt=%b required %b", name, idx, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] aa, input logic [63:0] bb);
    @(negedge clk);
    in_valid = v;
    stim_a   = aa;
    stim_b   = bb;
  endtask

  // Drive one 4-bit pair and check the unsigned and signed 4-bit instances one cycle later.
  task automatic vec(input string name, input logic [3:0] aa, input logic [3:0] bb,
                     input logic [3:0] req_u, input logic [3:0] req_s);
    drive(1'b1, {60'd0, aa}, {60'd0, bb});
    @(posedge clk);
    #1;
    check_lit({name, "_u"}, 0, req_u);
    check_lit({name, "_s"}, 1, req_s);
  endtask

  localparam logic [3:0] R_GT = 4'b1100;
  localparam logic [3:0] R_EQ = 4'b1010;
  localparam logic [3:0] R_LT = 4'b1001;

  initial begin
    logic [63:0] ra, rb;
    int          sel;

    repeat (2) @(negedge clk);
    check_lit("reset_state", 0, 4'b0000);
    check_lit("reset_state", 6, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    vec("gt_9_5",   4'b1001, 4'b0101, R_GT, R_LT);
    vec("eq_12",    4'b1100, 4'b1100, R_EQ, R_EQ);
    vec("eq_3",     4'b0011, 4'b0011, R_EQ, R_EQ);
    vec("lt_4_9",   4'b0100, 4'b1001, R_LT, R_GT);
    vec("lt_2_7",   4'b0010, 4'b0111, R_LT, R_LT);
    vec("lt_6_8",   4'b0110, 4'b1000, R_LT, R_GT);
    vec("max_min",  4'b1111, 4'b0000, R_GT, R_LT);
    vec("min_max",  4'b0000, 4'b1111, R_LT, R_GT);

    // Flags must hold the last result while in_valid is low.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk);
      #1;
      check_lit("hold_u", 0, 4'b0001);
      check_lit("hold_s", 1, 4'b0100);
    end

    // Asynchronous reset between edges, held across an edge with in_valid high.
    drive(1'b1, 64'hF, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("async_rst", 0, 4'b0000);
    check_lit("async_rst", 6, 4'b0000);
    @(posedge clk);
    #1;
    check_lit("rst_discard", 0, 4'b0000);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    stim_a   = 64'h9;
    stim_b   = 64'h5;
    @(posedge clk);
    #1;
    check_lit("post_rst_gt", 0, R_GT);

    for (int n = 0; n < 12000; n++) begin
      ra  = {$urandom, $urandom};
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1:    rb = ra;
        2:       rb = ~ra;
        3:       begin ra = '1; rb = '0; end
        4:       rb = ra ^ (64'd1 << $urandom_range(0, 63));
        default: rb = {$urandom, $urandom};
      endcase
      drive((n < 10000) ? 1'b1 : 1'($urandom_range(0, 1)), ra, rb);
    end

    drive(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/comparator.md
# comparator

Registered magnitude comparator for two WIDTH-bit operands that produces one-hot greater/equal/less flags. It sits in the datapath wherever a sampled operand pair must be ordered. Typical uses are threshold checks and sorter/selector control. Results are registered once, so downstream logic sees a clean, glitch-free flag set with a valid strobe.

## Interface
Parameters:
- WIDTH, default 4: operand width in bits, legal values 1 to 64.
- SIGNED, default 0: 0 compares unsigned; 1 compares two's-complement.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair a/b is sampled this cycle.
- a  input  WIDTH  left operand.
- b  input  WIDTH  right operand.
- out_valid  output  1  flags below hold a fresh result this cycle.
- greater  output  1  a > b.
- equal  output  1  a == b.
- less  output  1  a < b.

## Operation
- On a clk edge with in_valid=1:
  - compute the comparison of a against b;
  - register greater/equal/less;
  - set out_valid=1.
- On a clk edge with in_valid=0:
  - out_valid=0;
  - greater/equal/less hold their last values.
- Whenever a result is registered, exactly one of greater/equal/less is 1.
- SIGNED=0: plain unsigned order. 4'b1111 > 4'b0000.
- SIGNED=1: the MSB is the sign bit, so 4'b1111 (-1) < 4'b0000. Equality is bitwise in both modes.
- No X-propagation tolerance is required. X or Z on a/b while in_valid=1 gives undefined flags. With in_valid=0, a/b are ignored.
- There is no backpressure. Every in_valid pulse produces exactly one out_valid pulse one cycle later.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on the outputs after edge N.
- Back-to-back in_valid gives one result per cycle at full throughput.
- Reset, asserted asynchronously (rst_n=0):
  - out_valid=0, greater=0, equal=0, less=0 immediately, without waiting for a clock edge.
  - These are the only values at which all three flags may be 0 simultaneously.
- Reset mid-stream: any in-flight result is discarded. No out_valid is produced for a pair sampled on the same edge at which reset is active.
- Reset release: the first sample is on the first rising edge with rst_n=1.
- The combinational compare path must close timing at WIDTH=64 in one cycle. Use a log-depth tree, not a ripple chain.

## Structure
- Shared package: a cmp_result_t 3-bit enum encoding LT/EQ/GT as one-hot, plus a localparam for the maximum WIDTH.
- Sub-module cmp_cell, combinational, merges two adjacent (gt, eq) pairs:
  - higher-significance segment wins unless it is equal;
  - gt = gt_hi | (eq_hi & gt_lo);
  - eq = eq_hi & eq_lo.
- The top level builds a generate tree of cmp_cell from per-bit leaves, with bit gt = a_i & ~b_i and bit eq = ~(a_i ^ b_i).
  - Pad odd counts with an equal leaf.
  - For SIGNED=1, swap the roles of a and b at the MSB leaf.
- The output register stage lives in the top level.

## Test plan
WIDTH=4, SIGNED=0, in_valid=1 for each vector, check one cycle later:
- a=1001, b=0101 -> greater=1, equal=0, less=0, out_valid=1.
- a=1100, b=1100 -> equal=1. Likewise a=0011, b=0011 -> equal=1.
- a=0100, b=1001 -> less=1. Likewise a=0010, b=0111 -> less=1, and a=0110, b=1000 -> less=1.
- Extremes: a=1111, b=0000 -> greater=1; a=0000, b=1111 -> less=1. Rerun with SIGNED=1: 1111 vs 0000 -> less=1.

Control checks:
- Drop in_valid for 2 cycles -> out_valid=0 and the flags hold the previous result.
- Assert rst_n=0 between clock edges -> all outputs 0 immediately.
- Release reset, then apply 1001 vs 0101 -> greater=1 one cycle later.

Random sweep:
- WIDTH=1, 8, 64 in both SIGNED modes, 10k back-to-back vectors against a behavioural model.
- Every valid cycle must have exactly one flag set.
